// File: rtl/cpl_enqueue_arbiter.sv
// Shares one completion-queue manager enqueue interface among PORTS requesters:
// round-robin request and commit arbitration, tag-based response routing.
module cpl_enqueue_arbiter #(
  parameter int unsigned PORTS             = 4,
  parameter int unsigned QUEUE_INDEX_WIDTH = 5,
  parameter int unsigned REQ_TAG_WIDTH     = 8,
  parameter int unsigned OP_TAG_WIDTH      = 6,
  parameter int unsigned ADDR_WIDTH        = 64,
  parameter int unsigned MAX_OUTSTANDING   = 16
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [PORTS*QUEUE_INDEX_WIDTH-1:0]                    s_req_queue,
  input  logic [PORTS*(REQ_TAG_WIDTH-$clog2(PORTS))-1:0]        s_req_tag,
  input  logic [PORTS-1:0]                                      s_req_valid,
  output logic [PORTS-1:0]                                      s_req_ready,
  output logic [PORTS*ADDR_WIDTH-1:0]                           m_resp_addr,
  output logic [PORTS*(REQ_TAG_WIDTH-$clog2(PORTS))-1:0]        m_resp_tag,
  output logic [PORTS*OP_TAG_WIDTH-1:0]                         m_resp_op_tag,
  output logic [PORTS-1:0]                                      m_resp_full,
  output logic [PORTS-1:0]                                      m_resp_error,
  output logic [PORTS-1:0]                                      m_resp_valid,
  input  logic [PORTS-1:0]                                      m_resp_ready,
  input  logic [PORTS*OP_TAG_WIDTH-1:0]                         s_commit_op_tag,
  input  logic [PORTS-1:0]                                      s_commit_valid,
  output logic [PORTS-1:0]                                      s_commit_ready,
  output logic [QUEUE_INDEX_WIDTH-1:0]                          m_axis_enqueue_req_queue,
  output logic [REQ_TAG_WIDTH-1:0]                              m_axis_enqueue_req_tag,
  output logic                                                  m_axis_enqueue_req_valid,
  input  logic                                                  m_axis_enqueue_req_ready,
  input  logic [ADDR_WIDTH-1:0]                                 s_axis_enqueue_resp_addr,
  input  logic [REQ_TAG_WIDTH-1:0]                              s_axis_enqueue_resp_tag,
  input  logic [OP_TAG_WIDTH-1:0]                               s_axis_enqueue_resp_op_tag,
  input  logic                                                  s_axis_enqueue_resp_full,
  input  logic                                                  s_axis_enqueue_resp_error,
  input  logic                                                  s_axis_enqueue_resp_valid,
  output logic                                                  s_axis_enqueue_resp_ready,
  output logic [OP_TAG_WIDTH-1:0]                               m_axis_enqueue_commit_op_tag,
  output logic                                                  m_axis_enqueue_commit_valid,
  input  logic                                                  m_axis_enqueue_commit_ready
);
  localparam int unsigned PW = $clog2(PORTS);
  localparam int unsigned PT = REQ_TAG_WIDTH - PW;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  // Returns {found, index} of the first valid port at or after ptr, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [PORTS-1:0] v, input logic [PW-1:0] ptr);
    logic [PW-1:0] idx;
    rr_pick = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      idx = ptr + PW'(i);
      if (v[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  state_t         req_state, req_state_next;
  state_t         cmt_state, cmt_state_next;
  logic [PW-1:0]  req_ptr, req_gidx, cmt_ptr, cmt_gidx;
  logic           req_found, cmt_found, req_go, cmt_go;
  logic [CW-1:0]  count;
  logic           req_fire, resp_drain, resp_accept;
  logic [PW-1:0]  resp_port;

  logic [ADDR_WIDTH-1:0]   resp_addr_q;
  logic [PT-1:0]           resp_tag_q;
  logic [OP_TAG_WIDTH-1:0] resp_op_tag_q;
  logic                    resp_full_q, resp_error_q;

  assign {req_found, req_gidx} = rr_pick(s_req_valid, req_ptr);
  assign {cmt_found, cmt_gidx} = rr_pick(s_commit_valid, cmt_ptr);

  // Request path next state and one-hot grant.
  always_comb begin
    req_state_next = req_state;
    req_go         = 1'b0;
    s_req_ready    = '0;
    case (req_state)
      IDLE: if (rst && req_found && count != CW'(MAX_OUTSTANDING)) begin
        req_go                = 1'b1;
        s_req_ready[req_gidx] = 1'b1;
        req_state_next        = ISSUE;
      end
      ISSUE: if (m_axis_enqueue_req_ready) req_state_next = IDLE;
      default: req_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_state                <= IDLE;
      req_ptr                  <= '0;
      m_axis_enqueue_req_valid <= 1'b0;
      m_axis_enqueue_req_queue <= '0;
      m_axis_enqueue_req_tag   <= '0;
    end else begin
      req_state                <= req_state_next;
      m_axis_enqueue_req_valid <= (req_state_next == ISSUE);
      if (req_go) begin
        m_axis_enqueue_req_queue <= s_req_queue[req_gidx*QUEUE_INDEX_WIDTH +: QUEUE_INDEX_WIDTH];
        m_axis_enqueue_req_tag   <= {req_gidx, s_req_tag[req_gidx*PT +: PT]};
        req_ptr                  <= req_gidx + PW'(1);
      end
    end
  end

  // Commit path: same arbitration scheme, independent pointer.
  always_comb begin
    cmt_state_next = cmt_state;
    cmt_go         = 1'b0;
    s_commit_ready = '0;
    case (cmt_state)
      IDLE: if (rst && cmt_found) begin
        cmt_go                   = 1'b1;
        s_commit_ready[cmt_gidx] = 1'b1;
        cmt_state_next           = ISSUE;
      end
      ISSUE: if (m_axis_enqueue_commit_ready) cmt_state_next = IDLE;
      default: cmt_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmt_state                    <= IDLE;
      cmt_ptr                      <= '0;
      m_axis_enqueue_commit_valid  <= 1'b0;
      m_axis_enqueue_commit_op_tag <= '0;
    end else begin
      cmt_state                   <= cmt_state_next;
      m_axis_enqueue_commit_valid <= (cmt_state_next == ISSUE);
      if (cmt_go) begin
        m_axis_enqueue_commit_op_tag <= s_commit_op_tag[cmt_gidx*OP_TAG_WIDTH +: OP_TAG_WIDTH];
        cmt_ptr                      <= cmt_gidx + PW'(1);
      end
    end
  end

  // Response path: single holding register, routed by the port bits of the tag.
  assign resp_drain                = |(m_resp_valid & m_resp_ready);
  assign s_axis_enqueue_resp_ready = rst & (~(|m_resp_valid) | resp_drain);
  assign resp_accept               = s_axis_enqueue_resp_valid & s_axis_enqueue_resp_ready;
  assign resp_port                 = s_axis_enqueue_resp_tag[REQ_TAG_WIDTH-1 -: PW];

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_resp_valid  <= '0;
      resp_addr_q   <= '0;
      resp_tag_q    <= '0;
      resp_op_tag_q <= '0;
      resp_full_q   <= 1'b0;
      resp_error_q  <= 1'b0;
    end else if (resp_accept) begin
      m_resp_valid  <= PORTS'(1) << resp_port;
      resp_addr_q   <= s_axis_enqueue_resp_addr;
      resp_tag_q    <= s_axis_enqueue_resp_tag[PT-1:0];
      resp_op_tag_q <= s_axis_enqueue_resp_op_tag;
      resp_full_q   <= s_axis_enqueue_resp_full;
      resp_error_q  <= s_axis_enqueue_resp_error;
    end else if (resp_drain) begin
      m_resp_valid <= '0;
    end
  end

  assign m_resp_addr   = {PORTS{resp_addr_q}};
  assign m_resp_tag    = {PORTS{resp_tag_q}};
  assign m_resp_op_tag = {PORTS{resp_op_tag_q}};
  assign m_resp_full   = {PORTS{resp_full_q}};
  assign m_resp_error  = {PORTS{resp_error_q}};

  // Outstanding requests: issued to the manager but not yet returned to a port.
  assign req_fire = m_axis_enqueue_req_valid & m_axis_enqueue_req_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (req_fire && !resp_drain) begin
      count <= count + CW'(1);
    end else if (!req_fire && resp_drain && count != '0) begin
      count <= count - CW'(1);
    end
  end

endmodule
